// File: rtl/fifo_serial_pkg.sv
// Shared definitions for the FIFO-drained serial transmitter (and later the receive side).
// Holds the FSM encoding and the frame-length helper.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Clock cycles occupied by one complete frame on the line.
  function automatic int frame_clks(input int data_width, input int clks_per_bit,
                                    input int parity_en, input int stop_bits);
    return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
  endfunction

  localparam int FRAME_CLKS_8N1 = frame_clks(8, 16, 0, 1);

endpackage

// File: rtl/fifo_serial_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A synchronous clear restarts the period; shared with the receive path.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] tick_cnt;

  assign tick = (tick_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a first-word-fall-through FIFO and sends them as async serial frames:
// start, DATA_WIDTH bits LSB first, optional parity, STOP_BITS stop bits.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_deq,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int   TICK_W  = $clog2(CLKS_PER_BIT);
  localparam int   BIT_W   = $clog2(DATA_WIDTH + 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   shift, shift_nxt;
  logic                    par, par_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic                    tx_nxt;
  logic                    tick, tick_clr;
  logic                    bit_end, last_stop, load;

  // The bit timer is held at zero while idle and restarted on every load,
  // so each frame's start bit gets a full period.
  assign tick_clr = load | (state == IDLE);

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (TICK_W)
  ) u_baud_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign bit_end   = tick & (state != IDLE);
  assign last_stop = (state == STOP) & bit_end & (bit_cnt == LAST_STOP);
  assign load      = rstn & enable & ~fifo_empty & ((state == IDLE) | last_stop);

  assign fifo_deq   = load;
  assign frame_done = rstn & last_stop;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    par_nxt     = par;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = 1'b1;

    if (load) begin
      shift_nxt   = fifo_data;
      par_nxt     = (^fifo_data) ^ ODD_BIT;
      state_nxt   = START;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: ;
        START: begin
          if (bit_end) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_nxt = shift >> 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt_nxt = '0;
              state_nxt   = PAR_EN ? PARITY : STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_nxt   = STOP;
            bit_cnt_nxt = '0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              state_nxt   = IDLE;
              bit_cnt_nxt = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
            end
          end
        end
        default: begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end

    // The line is registered, so it is driven from the state being entered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
    par   <= par_nxt;
  end

endmodule
